// File: rtl/mem_miss_servicer_pkg.sv
// Shared types for the two-port cache miss servicer: controller states,
// store size codes, the latched request record and line alignment.
package mem_miss_servicer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_REQ,
    WR_RSP,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    SIZE_B = 3'b000,
    SIZE_H = 3'b001,
    SIZE_W = 3'b010,
    SIZE_D = 3'b011
  } size_t;

  localparam logic PORT1 = 1'b0;
  localparam logic PORT2 = 1'b1;

  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    size_t       size;
    logic [63:0] data;
    logic        port;
  } req_t;

  function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned off);
    return addr & ~((64'd1 << off) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_miss_servicer_if.sv
// Downstream memory bus: one request channel with valid/ready and one
// response channel that the memory pushes without back-pressure.
interface mem_miss_servicer_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_req_addr;
  logic        bus_req_write;
  logic [2:0]  bus_req_size;
  logic [63:0] bus_req_data;
  logic [7:0]  bus_req_len;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_data;
  logic        bus_rsp_last;

  modport master (
    output bus_req_valid, bus_req_addr, bus_req_write, bus_req_size, bus_req_data, bus_req_len,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_last
  );

  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_write, bus_req_size, bus_req_data, bus_req_len,
    output bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_last
  );
endinterface

// File: rtl/miss_arb.sv
// Two-way round-robin arbiter; the last-served pointer advances only when
// the controller actually accepts the grant.
module miss_arb
  import mem_miss_servicer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant_port
);

  logic last_port;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
    grant_valid = |req;
    grant_port  = PORT1;
    if (req == 2'b11) grant_port = ~last_port;
    else if (req[1])  grant_port = PORT2;
  end

  // Pointing at port 2 after reset hands port 1 the first contested grant.
  always_ff @(posedge clk) begin
    if (!reset_n)                     last_port <= PORT2;
    else if (accept && grant_valid)   last_port <= grant_port;
  end

endmodule

// File: rtl/mem_miss_servicer.sv
// Services one cache miss at a time from two requesters: line fills become
// B-beat bus reads streamed back as fill beats, stores become single-beat writes.
module mem_miss_servicer
  import mem_miss_servicer_pkg::*;
#(
  parameter int B   = 8,
  parameter int OFF = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 MEM_miss1,
  input  logic [63:0]          MEM_addr1,
  input  logic                 MEM_Write1,
  input  logic [2:0]           MEM_Size1,
  input  logic [63:0]          MEM_Data1,
  input  logic                 MEM_miss2,
  input  logic [63:0]          MEM_addr2,
  input  logic                 MEM_Write2,
  input  logic [2:0]           MEM_Size2,
  input  logic [63:0]          MEM_Data2,
  output logic                 done1,
  output logic                 done2,
  output logic                 fill_valid,
  output logic                 fill_port,
  output logic [63:0]          fill_addr,
  output logic [$clog2(B)-1:0] fill_beat,
  output logic [63:0]          fill_data,
  output logic                 fill_last,
  mem_miss_servicer_if.master  bus
);

  localparam int              BW        = $clog2(B);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(B - 1);
  localparam logic [7:0]      READ_LEN  = 8'(B - 1);

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic          txn_port;
  logic          txn_write;
  logic [63:0]   txn_line;

  logic   grant_valid;
  logic   grant_port;
  logic   accept;
  req_t   granted;

  assign accept = (state == IDLE);

  miss_arb u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         ({MEM_miss2, MEM_miss1}),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    granted      = '0;
    granted.port = grant_port;
    if (grant_port == PORT2) begin
      granted.addr  = MEM_addr2;
      granted.write = MEM_Write2;
      granted.size  = size_t'(MEM_Size2);
      granted.data  = MEM_Data2;
    end else begin
      granted.addr  = MEM_addr1;
      granted.write = MEM_Write1;
      granted.size  = size_t'(MEM_Size1);
      granted.data  = MEM_Data1;
    end
  end

  // NOTE: all state and registered outputs use <= so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      beat_cnt          <= '0;
      txn_port          <= PORT1;
      txn_write         <= 1'b0;
      txn_line          <= '0;
      done1             <= 1'b0;
      done2             <= 1'b0;
      fill_valid        <= 1'b0;
      fill_port         <= 1'b0;
      fill_addr         <= '0;
      fill_beat         <= '0;
      fill_data         <= '0;
      fill_last         <= 1'b0;
      bus.bus_req_valid <= 1'b0;
      bus.bus_req_addr  <= '0;
      bus.bus_req_write <= 1'b0;
      bus.bus_req_size  <= '0;
      bus.bus_req_data  <= '0;
      bus.bus_req_len   <= '0;
    end else begin
      done1      <= 1'b0;
      done2      <= 1'b0;
      fill_valid <= 1'b0;
      fill_last  <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            txn_port          <= granted.port;
            txn_write         <= granted.write;
            txn_line          <= line_align(granted.addr, OFF);
            beat_cnt          <= '0;
            bus.bus_req_valid <= 1'b1;
            bus.bus_req_write <= granted.write;
            if (granted.write) begin
              bus.bus_req_addr <= granted.addr;
              bus.bus_req_size <= granted.size;
              bus.bus_req_data <= granted.data;
              bus.bus_req_len  <= '0;
              state            <= WR_REQ;
            end else begin
              bus.bus_req_addr <= line_align(granted.addr, OFF);
              bus.bus_req_size <= SIZE_D;
              bus.bus_req_data <= '0;
              bus.bus_req_len  <= READ_LEN;
              state            <= RD_REQ;
            end
          end
        end

        RD_REQ, WR_REQ: begin
          if (bus.bus_req_ready) begin
            bus.bus_req_valid <= 1'b0;
            state             <= (state == RD_REQ) ? RD_DATA : WR_RSP;
          end
        end

        RD_DATA: begin
          if (bus.bus_rsp_valid) begin
            fill_valid <= 1'b1;
            fill_port  <= txn_port;
            fill_addr  <= txn_line;
            fill_beat  <= beat_cnt;
            fill_data  <= bus.bus_rsp_data;
            // An early last from the bus ends the line without wrapping the counter.
            if (beat_cnt == LAST_BEAT || bus.bus_rsp_last) begin
              fill_last <= 1'b1;
              state     <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        WR_RSP: begin
          if (bus.bus_rsp_valid) begin
            done1 <= (txn_port == PORT1);
            done2 <= (txn_port == PORT2);
            state <= DONE;
          end
        end

        DONE: begin
          // Fills report completion the cycle after fill_last; stores already did on the ack.
          if (!txn_write) begin
            done1 <= (txn_port == PORT1);
            done2 <= (txn_port == PORT2);
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
